// File: rtl/cut_response_analyzer.sv
// cut_response_analyzer
// Compares the output of a circuit under test against a fault-free reference
// for each applied 5-bit vector. It counts mismatches, with saturation, and
// captures the first failing vector. It also compacts the CUT response into a
// single-input MISR signature.
// Optional build macro: CRA_GOLDEN_SIG_EN adds the GOLDEN_SIG parameter and the
// sig_match output, and folds the signature comparison into pass.
module cut_response_analyzer #(
    parameter int unsigned       NUM_VEC = 32,
    parameter int unsigned       CNT_W   = 6,
    parameter int unsigned       SIG_W   = 16,
    parameter logic [SIG_W-1:0]  POLY    = 16'h1021,
    parameter logic [SIG_W-1:0]  SEED    = 16'h0000
`ifdef CRA_GOLDEN_SIG_EN
    ,
    parameter logic [SIG_W-1:0]  GOLDEN_SIG = '0
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pat_valid,
    input  logic [4:0]       pat_vec,
    input  logic             z_dut,
    input  logic             z_ref,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             first_fail_vld,
    output logic [4:0]       first_fail_vec,
    output logic [SIG_W-1:0] signature
`ifdef CRA_GOLDEN_SIG_EN
    ,
    output logic             sig_match
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] LAST_VEC = 8'(NUM_VEC - 1);

    state_t           state, state_nxt;
    logic [7:0]       vcnt, vcnt_nxt;
    logic             busy_nxt, done_nxt, pass_nxt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             ffv_vld_nxt;
    logic [4:0]       ffv_nxt;
    logic [SIG_W-1:0] sig_nxt;
    logic             accept;
    logic             mism;
    logic [SIG_W-1:0] sig_step;
`ifdef CRA_GOLDEN_SIG_EN
    logic             sig_match_nxt;
`endif

    assign accept   = (state == RUN) && pat_valid;
    assign mism     = z_dut ^ z_ref;
    assign sig_step = {signature[SIG_W-2:0], 1'b0}
                    ^ (signature[SIG_W-1] ? POLY : '0)
                    ^ {{(SIG_W-1){1'b0}}, z_dut};

    // Next-state and next-result logic; every register holds unless updated
    always_comb begin
        state_nxt   = state;
        vcnt_nxt    = vcnt;
        cnt_nxt     = mismatch_cnt;
        ffv_vld_nxt = first_fail_vld;
        ffv_nxt     = first_fail_vec;
        sig_nxt     = signature;
        done_nxt    = done;
        pass_nxt    = pass;
`ifdef CRA_GOLDEN_SIG_EN
        sig_match_nxt = sig_match;
`endif
        case (state)
            IDLE, DONE: begin
                // A start wins over a simultaneous pat_valid: that vector is dropped
                if (start) begin
                    state_nxt   = RUN;
                    vcnt_nxt    = '0;
                    cnt_nxt     = '0;
                    ffv_vld_nxt = 1'b0;
                    ffv_nxt     = '0;
                    sig_nxt     = SEED;
                    done_nxt    = 1'b0;
                    pass_nxt    = 1'b0;
`ifdef CRA_GOLDEN_SIG_EN
                    sig_match_nxt = 1'b0;
`endif
                end
            end
            RUN: begin
                if (accept) begin
                    vcnt_nxt = vcnt + 8'd1;
                    sig_nxt  = sig_step;
                    if (mism) begin
                        if (mismatch_cnt != '1) begin
                            cnt_nxt = mismatch_cnt + 1'b1;
                        end
                        if (!first_fail_vld) begin
                            ffv_vld_nxt = 1'b1;
                            ffv_nxt     = pat_vec;
                        end
                    end
                    if (vcnt == LAST_VEC) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
`ifdef CRA_GOLDEN_SIG_EN
                        sig_match_nxt = (sig_step == GOLDEN_SIG);
                        pass_nxt      = (cnt_nxt == '0) && sig_match_nxt;
`else
                        pass_nxt      = (cnt_nxt == '0);
`endif
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        busy_nxt = (state_nxt == RUN);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Result registers; reset discards any partial session
    always_ff @(posedge clk) begin
        if (rst) begin
            vcnt           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_cnt   <= '0;
            first_fail_vld <= 1'b0;
            first_fail_vec <= '0;
            signature      <= SEED;
`ifdef CRA_GOLDEN_SIG_EN
            sig_match      <= 1'b0;
`endif
        end else begin
            vcnt           <= vcnt_nxt;
            busy           <= busy_nxt;
            done           <= done_nxt;
            pass           <= pass_nxt;
            mismatch_cnt   <= cnt_nxt;
            first_fail_vld <= ffv_vld_nxt;
            first_fail_vec <= ffv_nxt;
            signature      <= sig_nxt;
`ifdef CRA_GOLDEN_SIG_EN
            sig_match      <= sig_match_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_cut_response_analyzer.sv
// Testbench for cut_response_analyzer: directed scenarios plus randomized
// sessions, checked every cycle against a session-level behavioural model.
// Two instances share stimulus: default CNT_W and CNT_W=3 (saturation).
module tb_cut_response_analyzer;

    localparam int unsigned NUM_VEC = 32;
    localparam logic [15:0] POLY    = 16'h1021;
    localparam logic [15:0] SEED    = 16'h0000;

    function automatic logic [15:0] misr(input logic [15:0] s, input logic zd);
        logic [15:0] r;
        r = {s[14:0], 1'b0};
        if (s[15]) r = r ^ POLY;
        r[0] = r[0] ^ zd;
        return r;
    endfunction

    // Signature after n vectors of z_dut=1 starting from SEED
    function automatic logic [15:0] ones_sig(input int n);
        logic [15:0] s;
        s = SEED;
        for (int i = 0; i < n; i++) s = misr(s, 1'b1);
        return s;
    endfunction

    localparam logic [15:0] GOLD3 = ones_sig(32);

    logic clk = 0;
    logic rst, start, pat_valid, z_dut, z_ref;
    logic [4:0] pat_vec;

    logic        busy, done, pass, ffv_vld;
    logic [5:0]  cnt;
    logic [4:0]  ffv;
    logic [15:0] sig;
    logic        busy3, done3, pass3, ffv_vld3;
    logic [2:0]  cnt3;
    logic [4:0]  ffv3;
    logic [15:0] sig3;
`ifdef CRA_GOLDEN_SIG_EN
    logic sm, sm3;
`endif

    always #5 clk = ~clk;

    cut_response_analyzer #(.NUM_VEC(NUM_VEC), .CNT_W(6), .SIG_W(16), .POLY(POLY), .SEED(SEED)) dut (
        .clk(clk), .rst(rst), .start(start), .pat_valid(pat_valid), .pat_vec(pat_vec),
        .z_dut(z_dut), .z_ref(z_ref), .busy(busy), .done(done), .pass(pass),
        .mismatch_cnt(cnt), .first_fail_vld(ffv_vld), .first_fail_vec(ffv), .signature(sig)
`ifdef CRA_GOLDEN_SIG_EN
        , .sig_match(sm)
`endif
    );

    cut_response_analyzer #(.NUM_VEC(NUM_VEC), .CNT_W(3), .SIG_W(16), .POLY(POLY), .SEED(SEED)
`ifdef CRA_GOLDEN_SIG_EN
        , .GOLDEN_SIG(GOLD3)
`endif
    ) dut3 (
        .clk(clk), .rst(rst), .start(start), .pat_valid(pat_valid), .pat_vec(pat_vec),
        .z_dut(z_dut), .z_ref(z_ref), .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_cnt(cnt3), .first_fail_vld(ffv_vld3), .first_fail_vec(ffv3), .signature(sig3)
`ifdef CRA_GOLDEN_SIG_EN
        , .sig_match(sm3)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: the session is the list of accepted vectors;
    // every result is recomputed from that list.
    typedef struct {
        logic [4:0] vec;
        logic       zd;
        logic       zr;
    } rec_t;

    rec_t m_q[$];
    bit   m_run  = 0;
    bit   m_done = 0;
    bit   cmp_en = 0;

    int          e_mc;
    logic        e_vld;
    logic [4:0]  e_ffv;
    logic [15:0] e_sig;

    // Model update at the edge, then compare both instances 1ns later
    always @(posedge clk) begin
        if (rst) begin
            m_run = 0; m_done = 0; m_q.delete();
        end else if (!m_run && start) begin
            m_run = 1; m_done = 0; m_q.delete();
        end else if (m_run && pat_valid) begin
            m_q.push_back('{vec: pat_vec, zd: z_dut, zr: z_ref});
            if (m_q.size() == NUM_VEC) begin
                m_run = 0; m_done = 1;
            end
        end
        e_mc = 0; e_vld = 0; e_ffv = '0; e_sig = SEED;
        foreach (m_q[i]) begin
            if (m_q[i].zd != m_q[i].zr) begin
                e_mc++;
                if (!e_vld) begin e_vld = 1; e_ffv = m_q[i].vec; end
            end
            e_sig = misr(e_sig, m_q[i].zd);
        end
        #1;
        if (cmp_en) begin
            chk("busy", busy, m_run);
            chk("done", done, m_done);
            chk("mismatch_cnt", cnt, (e_mc > 63) ? 63 : e_mc);
            chk("first_fail_vld", ffv_vld, e_vld);
            chk("first_fail_vec", ffv, e_ffv);
            chk("signature", sig, e_sig);
            chk("busy3", busy3, m_run);
            chk("done3", done3, m_done);
            chk("mismatch_cnt3", cnt3, (e_mc > 7) ? 7 : e_mc);
            chk("first_fail_vld3", ffv_vld3, e_vld);
            chk("first_fail_vec3", ffv3, e_ffv);
            chk("signature3", sig3, e_sig);
`ifdef CRA_GOLDEN_SIG_EN
            chk("sig_match", sm, m_done && (e_sig == 16'h0000));
            chk("sig_match3", sm3, m_done && (e_sig == GOLD3));
            if (m_done) begin
                chk("pass", pass, (e_mc == 0) && (e_sig == 16'h0000));
                chk("pass3", pass3, (e_mc == 0) && (e_sig == GOLD3));
            end
`else
            if (m_done) begin
                chk("pass", pass, e_mc == 0);
                chk("pass3", pass3, e_mc == 0);
            end
`endif
        end
    end

    task automatic pulse_start();
        start = 1;
        @(negedge clk);
        start = 0;
    endtask

    task automatic apply(input logic [4:0] v, input logic zd, input logic zr, input int gaps);
        pat_valid = 1; pat_vec = v; z_dut = zd; z_ref = zr;
        @(negedge clk);
        pat_valid = 0;
        repeat (gaps) @(negedge clk);
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("done_within_bound", done, 1);
    endtask

    task automatic session_clean(input int gaps);
        pulse_start();
        for (int i = 0; i < 32; i++) apply(5'(i), 1'b0, 1'b0, gaps);
        wait_done();
    endtask

    initial begin
        rst = 1; start = 0; pat_valid = 0; pat_vec = '0; z_dut = 0; z_ref = 0;
        repeat (2) @(negedge clk);
        cmp_en = 1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", cnt, 0);
        chk("rst_sig", sig, 16'h0000);
        rst = 0;
        @(negedge clk);

        // 1: clean session
        session_clean(0);
        chk("s1_pass", pass, 1);
        chk("s1_cnt", cnt, 0);
        chk("s1_vld", ffv_vld, 0);
        chk("s1_sig", sig, 16'h0000);
        chk("s1_busy", busy, 0);

        // 2: mismatches at vectors 5 and 17
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            logic zr;
            zr = 1'($urandom_range(1));
            apply(5'(i), zr ^ ((i == 5) || (i == 17)), zr, 0);
        end
        wait_done();
        chk("s2_cnt", cnt, 2);
        chk("s2_ffv", ffv, 5'b00101);
        chk("s2_vld", ffv_vld, 1);
        chk("s2_pass", pass, 0);

        // 3: clean session with 3 idle cycles between vectors
        session_clean(3);
        chk("s3_pass", pass, 1);
        chk("s3_sig", sig, 16'h0000);

        // 4: reset after 10 vectors, one of them mismatching
        pulse_start();
        for (int i = 0; i < 10; i++) apply(5'(i), i == 3, 1'b0, 0);
        chk("s4_pre_cnt", cnt, 1);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("s4_busy", busy, 0);
        chk("s4_cnt", cnt, 0);
        chk("s4_vld", ffv_vld, 0);
        chk("s4_sig", sig, SEED);
        session_clean(0);
        chk("s4_pass", pass, 1);

        // 5: start at vector 8 ignored; pat_valid in DONE and IDLE ignored
        pulse_start();
        for (int i = 0; i < 32; i++) begin
            if (i == 8) start = 1;
            apply(5'(i), 1'b0, 1'b0, 0);
            start = 0;
        end
        wait_done();
        chk("s5_done", done, 1);
        repeat (4) apply(5'($urandom), 1'b1, 1'b0, 1);
        chk("s5_done_hold_cnt", cnt, 0);
        rst = 1; @(negedge clk); rst = 0;
        repeat (4) apply(5'($urandom), 1'b1, 1'b0, 1);
        chk("s5_idle_cnt", cnt, 0);
        chk("s5_idle_sig", sig, SEED);
        chk("s5_idle_busy", busy, 0);

        // 6: every vector mismatching, random vector order
        begin
            logic [4:0] first;
            first = 5'($urandom);
            pulse_start();
            for (int i = 0; i < 32; i++) apply((i == 0) ? first : 5'($urandom), 1'b1, 1'b0, 0);
            wait_done();
            chk("s6_cnt3", cnt3, 7);
            chk("s6_cnt", cnt, 32);
            chk("s6_ffv", ffv3, first);
            chk("s6_pass3", pass3, 0);
`ifdef CRA_GOLDEN_SIG_EN
            chk("s6_sig_match3", sm3, 1);
`endif
        end

        // Single z_dut=1 at vector 15 leaves exactly POLY in the register
        pulse_start();
        for (int i = 0; i < 32; i++) apply(5'(i), i == 15, i == 15, 0);
        wait_done();
        chk("poly_sig", sig, 16'h1021);

        // Start together with pat_valid in DONE: that vector is not accepted
        begin
            int guard;
            start = 1; pat_valid = 1; pat_vec = 5'h1F; z_dut = 1; z_ref = 0;
            @(negedge clk);
            start = 0; pat_valid = 0;
            chk("startpv_cnt", cnt, 0);
            guard = 0;
            while (!m_done && guard < 2000) begin
                pat_valid = 1'($urandom_range(1));
                pat_vec = 5'($urandom);
                z_ref = 1'($urandom_range(1));
                z_dut = z_ref ^ ($urandom_range(9) == 0);
                @(negedge clk);
                guard++;
            end
            pat_valid = 0;
            chk("startpv_bound", m_done, 1);
        end

        // Randomized sessions: sparse pat_valid, stray starts, occasional reset
        for (int s = 0; s < 8; s++) begin
            int guard;
            start = 1; pat_valid = 1'($urandom_range(1));
            @(negedge clk);
            start = 0;
            guard = 0;
            while (!m_done && m_run && guard < 2000) begin
                pat_valid = ($urandom_range(3) != 0);
                pat_vec = 5'($urandom);
                z_ref = 1'($urandom_range(1));
                z_dut = z_ref ^ ($urandom_range(3) == 0);
                start = ($urandom_range(15) == 0);
                rst = (s == 5) && ($urandom_range(40) == 0);
                @(negedge clk);
                rst = 0;
                guard++;
            end
            start = 0; pat_valid = 0;
            chk("rand_bound", guard < 2000, 1);
            repeat (2) @(negedge clk);
        end

        cmp_en = 0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
